// File: rtl/snn_axil_csr_pkg.sv
// snn_axil_csr shared definitions
// register map, field positions, response codes, reset defaults
package snn_csr_pkg;

   localparam logic [7:0] OFF_CTRL    = 8'h00;
   localparam logic [7:0] OFF_STATUS  = 8'h04;
   localparam logic [7:0] OFF_SPK_CNT = 8'h08;
   localparam logic [7:0] OFF_IRQ     = 8'h0C;
   localparam logic [7:0] OFF_LEAK    = 8'h10;
   localparam logic [7:0] OFF_THRESH  = 8'h14;
   localparam logic [7:0] OFF_REFRAC  = 8'h18;
   localparam logic [7:0] OFF_VERSION = 8'h1C;
   localparam logic [7:0] MAP_END     = 8'h20;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_SOFT   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int IRQ_DONE    = 0;
   localparam int IRQ_OVF     = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [31:0] DEF_VERSION = 32'h0001_0000;
   localparam logic [15:0] DEF_LEAK    = 16'd0;
   localparam logic [15:0] DEF_THRESH  = 16'd1000;
   localparam logic [7:0]  DEF_REFRAC  = 8'd5;

   // one byte lane of a strobed write
   function automatic logic [7:0] lane(
      input logic [7:0] old_b,
      input logic [7:0] new_b,
      input logic       en
   );
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/snn_axil_csr_if.sv
// snn_axil_csr AXI4-Lite bus bundle
// master drives requests, slave drives ready/response
interface snn_axil_csr_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid,
      output bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid,
      input  bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/snn_axil_csr_slave.sv
// snn_axil_slave_if: AXI4-Lite handshake engine
// AW/W held independently; one write and one read in flight
module snn_axil_slave_if
   import snn_csr_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              aclk,
   input  logic              areset,
   snn_axil_csr_if.slave     s_axi,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data,
   output logic [3:0]        o_wr_strb,
   input  logic              i_wr_err,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [31:0]       i_rd_data,
   input  logic              i_rd_err
);

   logic              r_aw_hold;
   logic              r_w_hold;
   logic [ADDR_W-1:0] r_awaddr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_bvalid;
   logic [1:0]        r_bresp;
   logic              r_rvalid;
   logic [31:0]       r_rdata;
   logic [1:0]        r_rresp;
   logic              w_aw_fire;
   logic              w_w_fire;
   logic              w_ar_fire;
   logic              w_unused;

   assign s_axi.awready = !areset && !r_aw_hold && !r_bvalid;
   assign s_axi.wready  = !areset && !r_w_hold && !r_bvalid;
   assign s_axi.arready = !areset && !r_rvalid;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;

   assign w_aw_fire = s_axi.awvalid && s_axi.awready;
   assign w_w_fire  = s_axi.wvalid && s_axi.wready;
   assign w_ar_fire = s_axi.arvalid && s_axi.arready;

   assign o_wr_en   = r_aw_hold && r_w_hold;
   assign o_wr_addr = r_awaddr;
   assign o_wr_data = r_wdata;
   assign o_wr_strb = r_wstrb;
   assign o_rd_en   = w_ar_fire;
   assign o_rd_addr = s_axi.araddr[ADDR_W-1:0];

   assign w_unused = &{1'b0, s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[31:ADDR_W],
                       s_axi.araddr[31:ADDR_W]};

   // capture AW and W, commit once both held, then hold B until bready
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_aw_hold <= 1'b0;
         r_w_hold  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         if (w_aw_fire) begin
            r_aw_hold <= 1'b1;
            r_awaddr  <= s_axi.awaddr[ADDR_W-1:0];
         end
         if (w_w_fire) begin
            r_w_hold <= 1'b1;
            r_wdata  <= s_axi.wdata;
            r_wstrb  <= s_axi.wstrb;
         end
         if (o_wr_en) begin
            r_aw_hold <= 1'b0;
            r_w_hold  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (r_bvalid && s_axi.bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // register read data on AR accept, hold R until rready
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_fire) begin
         r_rvalid <= 1'b1;
         r_rdata  <= i_rd_err ? 32'd0 : i_rd_data;
         r_rresp  <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && s_axi.rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/snn_axil_csr.sv
// snn_axil_csr: SNN accelerator control/status registers
// decode, config outputs, spike counter, sticky irq status
module snn_axil_csr
   import snn_csr_pkg::*;
#(
   parameter int          ADDR_W     = 8,
   parameter logic [31:0] VERSION    = DEF_VERSION,
   parameter logic [15:0] LEAK_RST   = DEF_LEAK,
   parameter logic [15:0] THRESH_RST = DEF_THRESH,
   parameter logic [7:0]  REFRAC_RST = DEF_REFRAC
) (
   input  logic          aclk,
   input  logic          areset,
   snn_axil_csr_if.slave s_axi,
   input  logic          core_busy,
   input  logic          core_done_pulse,
   input  logic          core_spike_pulse,
   output logic          cfg_enable,
   output logic          cfg_soft_reset,
   output logic [15:0]   cfg_leak,
   output logic [15:0]   cfg_thresh,
   output logic [7:0]    cfg_refrac,
   output logic          interrupt
);

   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [31:0]       w_wr_data;
   logic [3:0]        w_wr_strb;
   logic              w_wr_err;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [31:0]       w_rd_data;
   logic              w_rd_err;
   logic [ADDR_W-1:0] w_wr_off;
   logic [ADDR_W-1:0] w_rd_off;
   logic              w_unused;

   logic        r_enable, r_irq_en, r_soft;
   logic [15:0] r_leak, r_thresh;
   logic [7:0]  r_refrac;
   logic [31:0] r_spk;
   logic        r_done, r_ovf, r_irq;

   logic        w_enable_nxt, w_irq_en_nxt, w_soft_nxt;
   logic [15:0] w_leak_nxt, w_thresh_nxt;
   logic [7:0]  w_refrac_nxt;
   logic [31:0] w_spk_nxt;
   logic        w_done_nxt, w_ovf_nxt, w_irq_nxt;
   logic [1:0]  w_clr;
   logic        w_spk_sat;

   snn_axil_slave_if #(.ADDR_W(ADDR_W)) u_slave (
      .aclk      (aclk),
      .areset    (areset),
      .s_axi     (s_axi),
      .o_wr_en   (w_wr_en),
      .o_wr_addr (w_wr_addr),
      .o_wr_data (w_wr_data),
      .o_wr_strb (w_wr_strb),
      .i_wr_err  (w_wr_err),
      .o_rd_en   (w_rd_en),
      .o_rd_addr (w_rd_addr),
      .i_rd_data (w_rd_data),
      .i_rd_err  (w_rd_err)
   );

   assign w_wr_off  = {w_wr_addr[ADDR_W-1:2], 2'b00};
   assign w_rd_off  = {w_rd_addr[ADDR_W-1:2], 2'b00};
   assign w_wr_err  = w_wr_off >= ADDR_W'(MAP_END);
   assign w_spk_sat = &r_spk;

   assign cfg_enable     = r_enable;
   assign cfg_soft_reset = r_soft;
   assign cfg_leak       = r_leak;
   assign cfg_thresh     = r_thresh;
   assign cfg_refrac     = r_refrac;
   assign interrupt      = r_irq;

   assign w_unused = &{1'b0, w_rd_en, w_wr_addr[1:0], w_rd_addr[1:0],
                       w_wr_data[31:16], w_wr_strb[3:2]};

   // next-state of every register; hw set beats W1C, soft reset beats all
   always_comb begin
      w_enable_nxt = r_enable;
      w_irq_en_nxt = r_irq_en;
      w_soft_nxt   = 1'b0;
      w_leak_nxt   = r_leak;
      w_thresh_nxt = r_thresh;
      w_refrac_nxt = r_refrac;
      w_clr        = 2'b00;
      if (w_wr_en && !w_wr_err) begin
         case (w_wr_off)
            ADDR_W'(OFF_CTRL): if (w_wr_strb[0]) begin
               w_enable_nxt = w_wr_data[CTRL_EN];
               w_irq_en_nxt = w_wr_data[CTRL_IRQ_EN];
               w_soft_nxt   = w_wr_data[CTRL_SOFT];
            end
            ADDR_W'(OFF_IRQ): if (w_wr_strb[0]) begin
               w_clr = w_wr_data[1:0];
            end
            ADDR_W'(OFF_LEAK): w_leak_nxt = {
               lane(r_leak[15:8], w_wr_data[15:8], w_wr_strb[1]),
               lane(r_leak[7:0], w_wr_data[7:0], w_wr_strb[0])};
            ADDR_W'(OFF_THRESH): w_thresh_nxt = {
               lane(r_thresh[15:8], w_wr_data[15:8], w_wr_strb[1]),
               lane(r_thresh[7:0], w_wr_data[7:0], w_wr_strb[0])};
            ADDR_W'(OFF_REFRAC): w_refrac_nxt =
               lane(r_refrac, w_wr_data[7:0], w_wr_strb[0]);
            default: ;
         endcase
      end
      if (w_soft_nxt) begin
         w_spk_nxt  = 32'd0;
         w_done_nxt = 1'b0;
         w_ovf_nxt  = 1'b0;
      end else begin
         w_spk_nxt  = (core_spike_pulse && !w_spk_sat) ?
                      r_spk + 32'd1 : r_spk;
         w_done_nxt = (r_done & ~w_clr[IRQ_DONE]) | core_done_pulse;
         // a spike arriving while saturated is lost and flagged
         w_ovf_nxt  = (r_ovf & ~w_clr[IRQ_OVF]) |
                      (core_spike_pulse && w_spk_sat);
      end
      w_irq_nxt = w_irq_en_nxt & (w_done_nxt | w_ovf_nxt);
   end

   // read mux from current state, so a same-cycle write is not visible
   always_comb begin
      w_rd_data = 32'd0;
      w_rd_err  = 1'b0;
      case (w_rd_off)
         ADDR_W'(OFF_CTRL):    w_rd_data = {29'd0, r_irq_en, 1'b0, r_enable};
         ADDR_W'(OFF_STATUS):  w_rd_data = {31'd0, core_busy};
         ADDR_W'(OFF_SPK_CNT): w_rd_data = r_spk;
         ADDR_W'(OFF_IRQ):     w_rd_data = {30'd0, r_ovf, r_done};
         ADDR_W'(OFF_LEAK):    w_rd_data = {16'd0, r_leak};
         ADDR_W'(OFF_THRESH):  w_rd_data = {16'd0, r_thresh};
         ADDR_W'(OFF_REFRAC):  w_rd_data = {24'd0, r_refrac};
         ADDR_W'(OFF_VERSION): w_rd_data = VERSION;
         default:              w_rd_err  = 1'b1;
      endcase
   end

   // register state update
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_enable <= 1'b0;
         r_irq_en <= 1'b0;
         r_soft   <= 1'b0;
         r_leak   <= LEAK_RST;
         r_thresh <= THRESH_RST;
         r_refrac <= REFRAC_RST;
         r_spk    <= 32'd0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_enable <= w_enable_nxt;
         r_irq_en <= w_irq_en_nxt;
         r_soft   <= w_soft_nxt;
         r_leak   <= w_leak_nxt;
         r_thresh <= w_thresh_nxt;
         r_refrac <= w_refrac_nxt;
         r_spk    <= w_spk_nxt;
         r_done   <= w_done_nxt;
         r_ovf    <= w_ovf_nxt;
         r_irq    <= w_irq_nxt;
      end
   end

endmodule

// File: tb/tb_snn_axil_csr.sv
// tb_snn_axil_csr: directed bench for snn_axil_csr
// samples 1 time unit after each rising edge
module tb_snn_axil_csr;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        core_busy = 1'b0;
   logic        core_done_pulse = 1'b0;
   logic        core_spike_pulse = 1'b0;
   logic        cfg_enable;
   logic        cfg_soft_reset;
   logic [15:0] cfg_leak;
   logic [15:0] cfg_thresh;
   logic [7:0]  cfg_refrac;
   logic        interrupt;

   int n_cmp = 0;
   int n_err = 0;

   snn_axil_csr_if bus();

   snn_axil_csr dut (
      .aclk             (aclk),
      .areset           (areset),
      .s_axi            (bus),
      .core_busy        (core_busy),
      .core_done_pulse  (core_done_pulse),
      .core_spike_pulse (core_spike_pulse),
      .cfg_enable       (cfg_enable),
      .cfg_soft_reset   (cfg_soft_reset),
      .cfg_leak         (cfg_leak),
      .cfg_thresh       (cfg_thresh),
      .cfg_refrac       (cfg_refrac),
      .interrupt        (interrupt)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic issue_wr(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      bit aw_go, w_go;
      int n = 0;
      bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      while ((bus.awvalid || bus.wvalid) && n < 20) begin
         aw_go = bus.awvalid && bus.awready;
         w_go  = bus.wvalid && bus.wready;
         tick();
         n++;
         if (aw_go) bus.awvalid = 1'b0;
         if (w_go) bus.wvalid = 1'b0;
      end
      if (bus.awvalid || bus.wvalid) begin
         chk("wr_accept", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
         bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      end
   endtask

   task automatic wait_b(output int lat, output logic [1:0] resp);
      lat = 0;
      while (!bus.bvalid && lat < 20) begin
         tick();
         lat++;
      end
      resp = bus.bresp;
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] eresp);
      int lat;
      logic [1:0] r;
      issue_wr(a, d, s);
      wait_b(lat, r);
      chk({tag, "_lat"}, 32'(lat), 32'd1);
      chk({tag, "_bresp"}, {30'd0, r}, {30'd0, eresp});
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input logic [31:0] ed, input logic [1:0] er);
      int n = 0;
      bus.araddr = a;
      bus.arvalid = 1'b1;
      while (!bus.arready && n < 20) begin
         tick();
         n++;
      end
      tick();
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
      chk({tag, "_rdata"}, bus.rdata, ed);
      chk({tag, "_rresp"}, {30'd0, bus.rresp}, {30'd0, er});
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [1:0] r;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;

      repeat (3) tick();
      chk("rst_awready", {31'd0, bus.awready}, 32'd0);
      chk("rst_wready", {31'd0, bus.wready}, 32'd0);
      chk("rst_arready", {31'd0, bus.arready}, 32'd0);
      chk("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
      chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_enable", {31'd0, cfg_enable}, 32'd0);
      chk("rst_leak", {16'd0, cfg_leak}, 32'd0);
      chk("rst_thresh", {16'd0, cfg_thresh}, 32'd1000);
      chk("rst_refrac", {24'd0, cfg_refrac}, 32'd5);
      chk("rst_irq", {31'd0, interrupt}, 32'd0);
      areset = 1'b0;
      tick();
      chk("idle_awready", {31'd0, bus.awready}, 32'd1);

      rd("rd_leak0", 32'h10, 32'd0, 2'b00);
      rd("rd_thresh0", 32'h14, 32'd1000, 2'b00);
      rd("rd_refrac0", 32'h18, 32'd5, 2'b00);
      rd("rd_version", 32'h1C, 32'h0001_0000, 2'b00);

      wr("wr_leak", 32'h10, 32'd10, 4'hF, 2'b00);
      wr("wr_thresh", 32'h14, 32'd200, 4'hF, 2'b00);
      wr("wr_refrac", 32'h18, 32'd8, 4'hF, 2'b00);
      wr("wr_ctrl", 32'h00, 32'd1, 4'hF, 2'b00);
      chk("cfg_leak", {16'd0, cfg_leak}, 32'd10);
      chk("cfg_thresh", {16'd0, cfg_thresh}, 32'd200);
      chk("cfg_refrac", {24'd0, cfg_refrac}, 32'd8);
      chk("cfg_enable", {31'd0, cfg_enable}, 32'd1);

      bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      chk("wfirst_wready", {31'd0, bus.wready}, 32'd0);
      chk("wfirst_bvalid", {31'd0, bus.bvalid}, 32'd0);
      tick();
      tick();
      bus.awaddr = 32'h10; bus.awvalid = 1'b1;
      tick();
      bus.awaddr = 32'h14;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bhold_bvalid", {31'd0, bus.bvalid}, 32'd1);
         chk("bhold_awready", {31'd0, bus.awready}, 32'd0);
      end
      bus.awvalid = 1'b0;
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      chk("bhold_bdone", {31'd0, bus.bvalid}, 32'd0);
      chk("bhold_no_aw2", {31'd0, bus.awready}, 32'd1);
      chk("bhold_leak", {16'd0, cfg_leak}, 32'h55);
      chk("bhold_thresh", {16'd0, cfg_thresh}, 32'd200);

      wr("wr_strb", 32'h14, 32'hFFFF_FF33, 4'b0001, 2'b00);
      chk("strb_thresh", {16'd0, cfg_thresh}, 32'h33);
      wr("wr_unmapped", 32'h24, 32'hFFFF_FFFF, 4'hF, 2'b10);
      chk("unm_leak", {16'd0, cfg_leak}, 32'h55);
      chk("unm_thresh", {16'd0, cfg_thresh}, 32'h33);
      chk("unm_refrac", {24'd0, cfg_refrac}, 32'd8);
      rd("rd_unmapped", 32'h40, 32'd0, 2'b10);
      rd("rd_alias", 32'h119, 32'd8, 2'b00);

      for (int i = 0; i < 7; i++) begin
         core_spike_pulse = 1'b1;
         tick();
         core_spike_pulse = 1'b0;
         tick();
      end
      rd("rd_spk7", 32'h08, 32'd7, 2'b00);
      core_busy = 1'b1;
      rd("rd_busy", 32'h04, 32'd1, 2'b00);
      core_busy = 1'b0;

      wr("wr_irq_en", 32'h00, 32'd5, 4'hF, 2'b00);
      chk("irq_idle", {31'd0, interrupt}, 32'd0);
      core_done_pulse = 1'b1;
      tick();
      core_done_pulse = 1'b0;
      chk("irq_done", {31'd0, interrupt}, 32'd1);
      rd("rd_irq1", 32'h0C, 32'd1, 2'b00);

      issue_wr(32'h0C, 32'd1, 4'hF);
      core_done_pulse = 1'b1;
      tick();
      core_done_pulse = 1'b0;
      chk("w1c_race_bvalid", {31'd0, bus.bvalid}, 32'd1);
      wait_b(lat, r);
      chk("w1c_race_bresp", {30'd0, r}, 32'd0);
      rd("rd_irq_race", 32'h0C, 32'd1, 2'b00);
      chk("irq_race", {31'd0, interrupt}, 32'd1);
      wr("wr_w1c", 32'h0C, 32'd1, 4'hF, 2'b00);
      chk("irq_cleared", {31'd0, interrupt}, 32'd0);
      rd("rd_irq0", 32'h0C, 32'd0, 2'b00);

      core_done_pulse = 1'b1;
      tick();
      core_done_pulse = 1'b0;
      chk("irq_again", {31'd0, interrupt}, 32'd1);
      issue_wr(32'h00, 32'd7, 4'hF);
      chk("soft_pre", {31'd0, cfg_soft_reset}, 32'd0);
      tick();
      chk("soft_pulse", {31'd0, cfg_soft_reset}, 32'd1);
      tick();
      chk("soft_post", {31'd0, cfg_soft_reset}, 32'd0);
      wait_b(lat, r);
      chk("soft_bresp", {30'd0, r}, 32'd0);
      chk("soft_irq", {31'd0, interrupt}, 32'd0);
      rd("rd_spk_soft", 32'h08, 32'd0, 2'b00);
      rd("rd_irq_soft", 32'h0C, 32'd0, 2'b00);
      rd("rd_ctrl", 32'h00, 32'd5, 2'b00);

      issue_wr(32'h10, 32'h77, 4'hF);
      bus.bready = 1'b0;
      tick();
      chk("mid_bvalid", {31'd0, bus.bvalid}, 32'd1);
      areset = 1'b1;
      tick();
      chk("mid_rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
      chk("mid_rst_leak", {16'd0, cfg_leak}, 32'd0);
      chk("mid_rst_enable", {31'd0, cfg_enable}, 32'd0);
      areset = 1'b0;
      tick();
      chk("mid_rst_awready", {31'd0, bus.awready}, 32'd1);
      chk("mid_rst_thresh", {16'd0, cfg_thresh}, 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
